regfile_sb: RTL

Parametrised integer register file with multi-port combinational read, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits in ID of the 5-stage pipeline. It replaces the single-write/two-read combinational-write register file with a properly clocked, resettable array. The scoreboard lets the hazard unit stall on registers whose writeback is still in flight. It also provides a generic debug tap in place of fixed per-register outputs.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_sb.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared parameters, types and helpers for the ID-stage register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Register index for the default configuration.
    typedef logic [AW_DEF-1:0] reg_addr_t;

    // Low bit of read port k's address field inside the packed rd_addr bus.
    function automatic int get_rd_addr(input int k, input int aw = AW_DEF);
        return k * aw;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// population count. Issue sets a bit, writeback clears it, and when both
// hit the same register in one cycle the newer producer (issue) wins.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [NREGS-1:0] busy_d, busy_q;
    logic [AW:0]      busy_cnt_d, busy_cnt_q;

    // Next busy vector (clear first, then set so issue wins) and its count.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        busy_d = busy_q;
        if (wr_en && (wr_addr != '0)) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        busy_cnt_d = '0;
        for (int i = 1; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + (AW + 1)'(busy_d[i]);
        end
    end

    // Busy bits and count update together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file for ID: NRD combinational read ports with
// same-cycle write bypass, one clocked write port, a raw debug tap, and a
// pending-write scoreboard for the hazard unit. Register 0 reads as zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs_d [NREGS];
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_hit;

    // Writes to register 0 are dropped everywhere, including the bypass.
    assign wr_hit = wr_en && (wr_addr != '0);

    // Next array contents: a single-entry commit on a valid writeback.
    always_comb begin
        // NOTE: blocking assignments in combinational logic, so later
        // statements see the values earlier ones produced.
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register array; reset clears every entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is deliberately reset, so it is built from
            // flops rather than a RAM macro; reads after reset return zero.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: zero register, then write bypass, then the array.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            bypass;
        logic [XLEN-1:0] data;

        assign addr   = rd_addr[get_rd_addr(k, AW) +: AW];
        assign bypass = wr_hit && (wr_addr == addr);
        assign data   = (addr == '0) ? '0 :
                        bypass       ? wr_data : regs_q[addr];

        assign rd_data[k*XLEN +: XLEN] = data;
        // A same-cycle writeback clears the pending flag, matching the data.
        assign rd_busy[k] = (addr != '0) && busy[addr] && !bypass;
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule
